// File: rtl/noc_pkg.sv
// Shared types and constants for the local network interface.
package noc_pkg;

    localparam int FLIT_W  = 16;
    localparam int COORD_W = 4;

    // Bit positions inside the sticky error vector.
    localparam int ERR_CREDIT_OVF = 0;
    localparam int ERR_RX_OVF     = 1;
    localparam int ERR_MISROUTE   = 2;

    // Single-flit packet; the router only looks at dx/dy.
    typedef struct packed {
        logic [7:0]         payload;
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
    } flit_t;

endpackage

// File: rtl/ni_rx_fifo.sv
// First-word-fall-through FIFO for flits ejected by the router.
// Pointers carry one extra wrap bit so every slot is usable.
module ni_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_pop;
    logic         w_wr;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop & ~o_empty;
    // A pop frees the head slot in the same cycle, so a full FIFO still
    // accepts a push when it is also being popped.
    assign w_wr    = i_push & (~o_full | w_pop);
    assign o_ovf   = i_push & o_full & ~w_pop;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    // Read/write pointer advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/noc_local_ni.sv
// Network interface on a router's Local port: credit-controlled flit
// injection on TX, buffered ejection with credit return on RX.
module noc_local_ni
    import noc_pkg::*;
#(
    parameter int XCOORD   = 0,
    parameter int YCOORD   = 0,
    parameter int CREDITS  = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [COORD_W-1:0] tx_dest_x_i,
    input  logic [COORD_W-1:0] tx_dest_y_i,
    input  logic [7:0]        tx_payload_i,
    output logic [FLIT_W-1:0] net_data_o,
    output logic              net_enable_o,
    input  logic              net_credit_i,
    input  logic [FLIT_W-1:0] net_data_i,
    input  logic              net_enable_i,
    output logic              net_credit_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic [FLIT_W-1:0] rx_data_o,
    output logic [2:0]        err_o
);

    localparam int                 CW   = $clog2(CREDITS + 1);
    localparam logic [CW-1:0]      CMAX = CW'(CREDITS);
    localparam logic [COORD_W-1:0] MY_X = COORD_W'(XCOORD);
    localparam logic [COORD_W-1:0] MY_Y = COORD_W'(YCOORD);

    logic [CW-1:0] r_count;
    flit_t         r_tx_flit;
    logic          r_tx_en;
    logic          r_credit;
    logic [2:0]    r_err;

    flit_t w_tx_flit;
    flit_t w_rx_flit;
    logic  w_accept;
    logic  w_credit_ovf;
    logic  w_misroute;
    logic  w_pop;
    logic  w_rx_empty;
    logic  w_rx_ovf;
    logic  w_rx_full_unused;

    // TX side: ready depends only on the credit register.
    assign tx_ready_o        = (r_count != '0);
    assign w_accept          = tx_valid_i & tx_ready_o;
    assign w_credit_ovf      = net_credit_i & ~w_accept & (r_count == CMAX);
    assign w_tx_flit.payload = tx_payload_i;
    assign w_tx_flit.dx      = tx_dest_x_i;
    assign w_tx_flit.dy      = tx_dest_y_i;
    assign net_data_o        = r_tx_flit;
    assign net_enable_o      = r_tx_en;

    // Credit counter: accept spends one, returned credit adds one,
    // both together cancel; an excess credit saturates at CREDITS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= CMAX;
        end else if (w_accept && !net_credit_i) begin
            r_count <= r_count - CW'(1);
        end else if (!w_accept && net_credit_i && (r_count != CMAX)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Outgoing flit register: data holds until the next accept, strobe is one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_flit <= '0;
            r_tx_en   <= 1'b0;
        end else begin
            r_tx_en <= w_accept;
            if (w_accept) r_tx_flit <= w_tx_flit;
        end
    end

    // RX side.
    assign w_rx_flit  = flit_t'(net_data_i);
    assign w_misroute = net_enable_i & ((w_rx_flit.dx != MY_X) | (w_rx_flit.dy != MY_Y));
    assign rx_valid_o = ~w_rx_empty;
    assign w_pop      = rx_valid_o & rx_ready_i;
    assign net_credit_o = r_credit;

    // Full is not needed here: overflow already reports the only case that matters.
    ni_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .W     (FLIT_W)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (net_enable_i),
        .i_data  (net_data_i),
        .i_pop   (w_pop),
        .o_data  (rx_data_o),
        .o_full  (w_rx_full_unused),
        .o_empty (w_rx_empty),
        .o_ovf   (w_rx_ovf)
    );

    // One credit back to the router for every flit the core consumes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_credit <= 1'b0;
        else      r_credit <= w_pop;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= '0;
        end else begin
            if (w_credit_ovf) r_err[ERR_CREDIT_OVF] <= 1'b1;
            if (w_rx_ovf)     r_err[ERR_RX_OVF]     <= 1'b1;
            if (w_misroute)   r_err[ERR_MISROUTE]   <= 1'b1;
        end
    end

    assign err_o = r_err;

endmodule

// File: tb/tb_noc_local_ni.sv
// Scoreboard bench for noc_local_ni at node (1,1), CREDITS=4, RX_DEPTH=4.
module tb_noc_local_ni;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic [3:0]  tx_dest_x_i;
    logic [3:0]  tx_dest_y_i;
    logic [7:0]  tx_payload_i;
    logic [15:0] net_data_o;
    logic        net_enable_o;
    logic        net_credit_i;
    logic [15:0] net_data_i;
    logic        net_enable_i;
    logic        net_credit_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic [15:0] rx_data_o;
    logic [2:0]  err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int credits_seen = 0;
    bit prev_pop = 1'b0;
    logic [15:0] exp_tx[$];
    logic [15:0] exp_rx[$];

    noc_local_ni #(.XCOORD(1), .YCOORD(1), .CREDITS(4), .RX_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .tx_dest_x_i(tx_dest_x_i), .tx_dest_y_i(tx_dest_y_i), .tx_payload_i(tx_payload_i),
        .net_data_o(net_data_o), .net_enable_o(net_enable_o), .net_credit_i(net_credit_i),
        .net_data_i(net_data_i), .net_enable_i(net_enable_i), .net_credit_o(net_credit_o),
        .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    always begin
        @(negedge clk);
        if (!rst) begin
            prev_pop = 1'b0;
        end else begin
            if (net_enable_o) begin
                if (exp_tx.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL tx_unexpected: got flit %h, none expected", net_data_o);
                end else begin
                    check("tx_flit", net_data_o, exp_tx.pop_front());
                end
            end
            check("credit_pulse", {15'd0, net_credit_o}, {15'd0, prev_pop});
            if (net_credit_o) credits_seen++;
            if (rx_valid_o && rx_ready_i) begin
                if (exp_rx.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rx_unexpected: got flit %h, none expected", rx_data_o);
                end else begin
                    check("rx_flit", rx_data_o, exp_rx.pop_front());
                end
            end
            prev_pop = rx_valid_o && rx_ready_i;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b0; tx_valid_i = 0; tx_dest_x_i = 0; tx_dest_y_i = 0; tx_payload_i = 0;
        net_credit_i = 0; net_data_i = 0; net_enable_i = 0; rx_ready_i = 0;
        repeat (2) tick();
        check("rst_net_data", net_data_o, 16'h0000);
        check("rst_net_enable", {15'd0, net_enable_o}, 16'd0);
        check("rst_net_credit", {15'd0, net_credit_o}, 16'd0);
        check("rst_rx_valid", {15'd0, rx_valid_o}, 16'd0);
        check("rst_err", {13'd0, err_o}, 16'd0);
        check("rst_tx_ready", {15'd0, tx_ready_o}, 16'd1);
        rst = 1'b1;
        tick();

        // 1: four credits -> four flits, then stall
        tx_dest_x_i = 4'd2; tx_dest_y_i = 4'd3; tx_payload_i = 8'hA5;
        repeat (4) exp_tx.push_back(16'hA523);
        tx_valid_i = 1;
        repeat (6) tick();
        tx_valid_i = 0;
        check("t1_ready_zero", {15'd0, tx_ready_o}, 16'd0);
        repeat (2) tick();

        // 2: one credit back -> exactly one more flit
        net_credit_i = 1; tick(); net_credit_i = 0;
        check("t2_ready_after_credit", {15'd0, tx_ready_o}, 16'd1);
        tx_dest_x_i = 4'd4; tx_dest_y_i = 4'd7; tx_payload_i = 8'h5C;
        exp_tx.push_back(16'h5C47);
        tx_valid_i = 1; tick(); tx_valid_i = 0;
        check("t2_ready_zero", {15'd0, tx_ready_o}, 16'd0);
        repeat (2) tick();

        // 3: count=2, simultaneous accept+credit keeps 2
        net_credit_i = 1; tick(); tick();
        tx_dest_x_i = 4'd1; tx_dest_y_i = 4'd2; tx_payload_i = 8'h31;
        repeat (3) exp_tx.push_back(16'h3112);
        tx_valid_i = 1; tick();
        net_credit_i = 0;
        check("t3_ready_cnt2", {15'd0, tx_ready_o}, 16'd1);
        tick();
        check("t3_ready_cnt1", {15'd0, tx_ready_o}, 16'd1);
        tick();
        tx_valid_i = 0;
        check("t3_ready_zero", {15'd0, tx_ready_o}, 16'd0);
        repeat (2) tick();
        check("tx_queue_drained", 16'(exp_tx.size()), 16'd0);

        // 4: two flits through RX with core ready
        rx_ready_i = 1; c0 = credits_seen;
        exp_rx.push_back(16'h1111); exp_rx.push_back(16'h2211);
        net_enable_i = 1; net_data_i = 16'h1111; tick();
        net_data_i = 16'h2211; tick();
        net_enable_i = 0;
        repeat (4) tick();
        check("t4_credits", 16'(credits_seen - c0), 16'd2);
        check("t4_err", {13'd0, err_o}, 16'd0);
        check("t4_rx_empty", {15'd0, rx_valid_o}, 16'd0);

        // 5: overflow with core stalled, then drain
        rx_ready_i = 0; c0 = credits_seen;
        for (int i = 1; i <= 5; i++) begin
            net_enable_i = 1; net_data_i = 16'(i * 256 + 16'h11);
            if (i <= 4) exp_rx.push_back(16'(i * 256 + 16'h11));
            tick();
        end
        net_enable_i = 0;
        tick();
        check("t5_err_rxovf", {13'd0, err_o}, 16'h0002);
        check("t5_rx_valid", {15'd0, rx_valid_o}, 16'd1);
        check("t5_no_credit", 16'(credits_seen - c0), 16'd0);
        rx_ready_i = 1;
        repeat (6) tick();
        rx_ready_i = 0;
        check("t5_credits", 16'(credits_seen - c0), 16'd4);
        check("t5_rx_empty", {15'd0, rx_valid_o}, 16'd0);

        // 6: misroute, credit overflow, reset clears
        rx_ready_i = 1;
        exp_rx.push_back(16'h0023);
        net_enable_i = 1; net_data_i = 16'h0023; tick();
        net_enable_i = 0;
        repeat (3) tick();
        check("t6_err_misroute", {13'd0, err_o}, 16'h0006);
        net_credit_i = 1;
        repeat (4) tick();
        check("t6_no_ovf_at_max", {13'd0, err_o}, 16'h0006);
        tick();
        net_credit_i = 0;
        check("t6_err_creditovf", {13'd0, err_o}, 16'h0007);
        check("t6_ready", {15'd0, tx_ready_o}, 16'd1);
        rst = 1'b0;
        #1;
        check("t6_rst_err", {13'd0, err_o}, 16'd0);
        check("t6_rst_ready", {15'd0, tx_ready_o}, 16'd1);
        check("t6_rst_rx_valid", {15'd0, rx_valid_o}, 16'd0);
        tick();
        rst = 1'b1;
        tick();
        check("rx_queue_drained", 16'(exp_rx.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
